// File: rtl/player_pkg.sv
// player_pkg: shared states and default motion constants for the player block.
package player_pkg;
  typedef enum logic [1:0] {IDLE, RISE, FALL} state_t;
  localparam int SCREEN_H     = 480;
  localparam int PLAYER_H     = 60;
  localparam int DEF_GROUND_Y = SCREEN_H - PLAYER_H;
  localparam int DEF_JUMP_VEL = 12;
  localparam int DEF_GRAVITY  = 1;
  localparam int DEF_MAX_FALL = 15;
endpackage

// File: rtl/btn_edge.sv
// btn_edge: rising-edge detector producing a one-cycle pulse, async reset.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);
  logic prev;
  always_ff @(posedge clk or posedge rst)
    if (rst) prev <= 1'b0;
    else prev <= level;
  assign pulse = level & ~prev;
endmodule

// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl: per-frame jump/fall motion of the player sprite.
// Optional double jump enabled with macro PLAYER_DOUBLE_JUMP_EN.
module player_motion_ctrl
  import player_pkg::*;
#(
  parameter int GROUND_Y = DEF_GROUND_Y,
  parameter int JUMP_VEL = DEF_JUMP_VEL,
  parameter int GRAVITY  = DEF_GRAVITY,
  parameter int MAX_FALL = DEF_MAX_FALL
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       frame_tick_i,
  input  logic       jump_i,
  input  logic       freeze_i,
  output logic [8:0] luc_loc_o,
  output logic       airborne_o,
  output logic       landed_o
);
  state_t state, state_n;
  logic [8:0] y, y_n;
  logic [4:0] vel, vel_n, vel_up, vel_dn;
  logic [5:0] vel_sum;
  logic [9:0] y_dn;
  logic pending, jump_edge, pend, upd, landed_n;
`ifdef PLAYER_DOUBLE_JUMP_EN
  logic dj_used, dj_n;
`endif

  btn_edge u_jump (.clk(clk_i), .rst(rst_i), .level(jump_i), .pulse(jump_edge));

  assign upd     = frame_tick_i & ~freeze_i;
  assign pend    = pending | jump_edge;
  assign vel_up  = vel > 5'(GRAVITY) ? vel - 5'(GRAVITY) : 5'd0;
  assign vel_sum = {1'b0, vel} + 6'(GRAVITY);
  assign vel_dn  = vel_sum > 6'(MAX_FALL) ? 5'(MAX_FALL) : vel_sum[4:0];
  assign y_dn    = {1'b0, y} + {5'd0, vel_dn};

  always_comb begin
    state_n  = state;
    y_n      = y;
    vel_n    = vel;
    landed_n = 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
    dj_n     = dj_used;
`endif
    if (upd)
      case (state)
        IDLE: if (pend) begin
          state_n = RISE;
          vel_n   = 5'(JUMP_VEL);
        end
        RISE: if (y < {4'd0, vel}) begin
          y_n     = 9'd0;
          vel_n   = 5'd0;
          state_n = FALL;
        end else begin
          y_n     = y - {4'd0, vel};
          vel_n   = vel_up;
          state_n = vel_up == 5'd0 ? FALL : RISE;
        end
        FALL: if (y_dn >= 10'(GROUND_Y)) begin
          y_n      = 9'(GROUND_Y);
          vel_n    = 5'd0;
          state_n  = IDLE;
          landed_n = 1'b1;
        end else begin
          y_n   = y_dn[8:0];
          vel_n = vel_dn;
        end
        default: state_n = IDLE;
      endcase
`ifdef PLAYER_DOUBLE_JUMP_EN
    if (landed_n) dj_n = 1'b0;
    // mid-air press restarts the climb from the current height
    if (upd && state != IDLE && pend && !dj_used) begin
      state_n  = RISE;
      vel_n    = 5'(JUMP_VEL);
      y_n      = y;
      landed_n = 1'b0;
      dj_n     = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state      <= IDLE;
      y          <= 9'(GROUND_Y);
      vel        <= 5'd0;
      pending    <= 1'b0;
      airborne_o <= 1'b0;
      landed_o   <= 1'b0;
    end else begin
      state      <= state_n;
      y          <= y_n;
      vel        <= vel_n;
      pending    <= upd ? 1'b0 : pend;
      airborne_o <= state_n != IDLE;
      landed_o   <= landed_n;
    end

`ifdef PLAYER_DOUBLE_JUMP_EN
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) dj_used <= 1'b0;
    else dj_used <= dj_n;
`endif

  assign luc_loc_o = y;
endmodule

// File: tb/tb_player_motion_ctrl.sv
// tb_player_motion_ctrl: randomized and directed checks against a signed-velocity motion model.
module tb_player_motion_ctrl;
  localparam int GY = 420, JV = 12, G = 1, MF = 15;
  logic clk = 1'b0, rst = 1'b1, tick = 1'b0, jump = 1'b0, freeze = 1'b0;
  logic [8:0] y_o;
  logic air_o, land_o;
  int m_y, m_vy;
  bit m_air, m_pend, m_prev, m_land, m_dj;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  player_motion_ctrl dut (
    .clk_i(clk), .rst_i(rst), .frame_tick_i(tick), .jump_i(jump), .freeze_i(freeze),
    .luc_loc_o(y_o), .airborne_o(air_o), .landed_o(land_o)
  );

  task automatic model_reset();
    m_y = GY; m_vy = 0; m_air = 0; m_pend = 0; m_prev = 0; m_land = 0; m_dj = 0;
  endtask

  // model: height y grows downward, vy is upward speed (negative while falling)
  task automatic model_cycle(input bit j, input bit t, input bit f);
    if (j && !m_prev) m_pend = 1;
    m_prev = j;
    m_land = 0;
    if (t && !f) begin
      if (!m_air) begin
        if (m_pend) begin m_air = 1; m_vy = JV; end
      end
`ifdef PLAYER_DOUBLE_JUMP_EN
      else if (m_pend && !m_dj) begin m_vy = JV; m_dj = 1; end
`endif
      else if (m_vy > 0) begin
        if (m_y < m_vy) begin m_y = 0; m_vy = 0; end
        else begin m_y -= m_vy; m_vy = (m_vy > G) ? m_vy - G : 0; end
      end else begin
        m_vy = (m_vy - G < -MF) ? -MF : m_vy - G;
        if (m_y - m_vy >= GY) begin m_y = GY; m_vy = 0; m_air = 0; m_land = 1; m_dj = 0; end
        else m_y -= m_vy;
      end
      m_pend = 0;
    end
  endtask

  task automatic step(input bit j, input bit t, input bit f);
    @(negedge clk);
    jump = j; tick = t; freeze = f;
    model_cycle(j, t, f);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; jump = 0; tick = 0; freeze = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (y_o !== 9'd420 || air_o !== 1'b0 || land_o !== 1'b0) begin
      n_fail++; $display("FAIL reset: got y=%0d air=%b land=%b want 420/0/0", y_o, air_o, land_o);
    end
    @(negedge clk); rst = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0);
      n_chk++;
      if (y_o !== 9'd420 || air_o !== 1'b0 || land_o !== 1'b0) begin
        n_fail++; $display("FAIL idle_tick%0d: got y=%0d air=%b land=%b want 420/0/0", i, y_o, air_o, land_o);
      end
    end
  endtask

  task automatic test_single_jump();
    int ticks = 0, land_tick = 0;
    step(1, 0, 0);
    step(0, 0, 0);
    n_chk++;
    if (air_o !== 1'b0) begin n_fail++; $display("FAIL jump_before_tick: got air=%b want 0", air_o); end
    for (int i = 0; i < 60 && land_tick == 0; i++) begin
      step(0, 1, 0);
      ticks++;
      n_chk++;
      if (y_o !== m_y[8:0] || air_o !== m_air || land_o !== m_land) begin
        n_fail++; $display("FAIL single_tick%0d: got y=%0d air=%b land=%b want %0d/%b/%b", ticks, y_o, air_o, land_o, m_y, m_air, m_land);
      end
      if (ticks == 1) begin
        n_chk++;
        if (y_o !== 9'd420 || air_o !== 1'b1) begin n_fail++; $display("FAIL takeoff: got y=%0d air=%b want 420/1", y_o, air_o); end
      end
      if (ticks == 13) begin
        n_chk++;
        if (y_o !== 9'd342 || air_o !== 1'b1) begin n_fail++; $display("FAIL apex: got y=%0d air=%b want 342/1", y_o, air_o); end
      end
      if (land_o === 1'b1) land_tick = ticks;
    end
    n_chk++;
    if (land_tick != 25 || y_o !== 9'd420) begin
      n_fail++; $display("FAIL landing_tick: got tick=%0d y=%0d want 25/420", land_tick, y_o);
    end
    step(0, 0, 0);
    n_chk++;
    if (land_o !== 1'b0 || air_o !== 1'b0) begin n_fail++; $display("FAIL landed_pulse_width: got land=%b air=%b want 0/0", land_o, air_o); end
  endtask

  task automatic test_same_cycle();
    int ticks = 1, land_tick = 0;
    step(1, 1, 0);
    n_chk++;
    if (y_o !== 9'd420 || air_o !== 1'b1) begin n_fail++; $display("FAIL same_cycle_take: got y=%0d air=%b want 420/1", y_o, air_o); end
    for (int i = 0; i < 60 && land_tick == 0; i++) begin
      if (ticks == 5) step(1, 1, 0);
      else step(0, 1, 0);
      ticks++;
      n_chk++;
      if (y_o !== m_y[8:0] || air_o !== m_air || land_o !== m_land) begin
        n_fail++; $display("FAIL same_cycle_tick%0d: got y=%0d air=%b land=%b want %0d/%b/%b", ticks, y_o, air_o, land_o, m_y, m_air, m_land);
      end
      if (land_o === 1'b1) land_tick = ticks;
    end
`ifndef PLAYER_DOUBLE_JUMP_EN
    n_chk++;
    if (land_tick != 25) begin n_fail++; $display("FAIL air_press_ignored: got land tick=%0d want 25", land_tick); end
`endif
  endtask

  task automatic test_freeze();
    int ticks = 1, land_tick = 0;
    step(1, 1, 0);
    repeat (4) begin step(0, 1, 0); ticks++; end
    for (int i = 0; i < 10; i++) begin
      step(i == 3, 1, 1);
      n_chk++;
      if (y_o !== 9'd378 || air_o !== 1'b1 || land_o !== 1'b0) begin
        n_fail++; $display("FAIL freeze_hold%0d: got y=%0d air=%b want 378/1", i, y_o, air_o);
      end
    end
    step(0, 1, 0);
    ticks++;
    n_chk++;
    if (y_o !== 9'd370) begin n_fail++; $display("FAIL freeze_resume: got y=%0d want 370", y_o); end
    for (int i = 0; i < 60 && land_tick == 0; i++) begin
      step(0, 1, 0);
      ticks++;
      n_chk++;
      if (y_o !== m_y[8:0] || air_o !== m_air || land_o !== m_land) begin
        n_fail++; $display("FAIL freeze_tick%0d: got y=%0d air=%b land=%b want %0d/%b/%b", ticks, y_o, air_o, land_o, m_y, m_air, m_land);
      end
      if (land_o === 1'b1) land_tick = ticks;
    end
`ifndef PLAYER_DOUBLE_JUMP_EN
    n_chk++;
    if (land_tick != 25) begin n_fail++; $display("FAIL freeze_landing: got tick=%0d want 25", land_tick); end
`endif
  endtask

  task automatic test_async_reset();
    step(1, 1, 0);
    repeat (18) step(0, 1, 0);
    n_chk++;
    if (air_o !== 1'b1 || y_o === 9'd420) begin n_fail++; $display("FAIL mid_fall: got y=%0d air=%b want airborne", y_o, air_o); end
    @(negedge clk);
    tick = 0;
    #2 rst = 1;
    #1;
    n_chk++;
    if (y_o !== 9'd420 || air_o !== 1'b0 || land_o !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got y=%0d air=%b land=%b want 420/0/0", y_o, air_o, land_o);
    end
    model_reset();
    @(negedge clk); rst = 0;
    step(0, 1, 0);
    n_chk++;
    if (y_o !== 9'd420 || air_o !== 1'b0) begin n_fail++; $display("FAIL post_reset_tick: got y=%0d air=%b want 420/0", y_o, air_o); end
  endtask

`ifdef PLAYER_DOUBLE_JUMP_EN
  task automatic test_double_jump();
    int land_tick = 0;
    step(1, 1, 0);
    repeat (12) step(0, 1, 0);
    n_chk++;
    if (y_o !== 9'd342) begin n_fail++; $display("FAIL dj_apex1: got y=%0d want 342", y_o); end
    step(1, 1, 0);
    repeat (12) step(0, 1, 0);
    n_chk++;
    if (y_o !== 9'd264 || air_o !== 1'b1) begin n_fail++; $display("FAIL dj_apex2: got y=%0d want 264", y_o); end
    step(1, 1, 0);
    for (int i = 0; i < 60 && land_tick == 0; i++) begin
      step(0, 1, 0);
      n_chk++;
      if (y_o !== m_y[8:0] || air_o !== m_air || land_o !== m_land) begin
        n_fail++; $display("FAIL dj_tick%0d: got y=%0d air=%b land=%b want %0d/%b/%b", i, y_o, air_o, land_o, m_y, m_air, m_land);
      end
      if (land_o === 1'b1) land_tick = i + 1;
    end
    n_chk++;
    if (land_tick == 0 || y_o !== 9'd420) begin n_fail++; $display("FAIL dj_landing: got y=%0d landed=%0d want 420", y_o, land_tick); end
  endtask
`endif

  task automatic test_random();
    bit j = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) j = ~j;
      step(j, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
      n_chk++;
      if (y_o !== m_y[8:0] || air_o !== m_air || land_o !== m_land || y_o > 9'd420) begin
        n_fail++; $display("FAIL random_cyc%0d: got y=%0d air=%b land=%b want %0d/%b/%b", i, y_o, air_o, land_o, m_y, m_air, m_land);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_jump();
    test_same_cycle();
    test_freeze();
    test_async_reset();
`ifdef PLAYER_DOUBLE_JUMP_EN
    test_double_jump();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/player_motion_ctrl.md
PLAYER_MOTION_CTRL -- requirements
Module: player_motion_ctrl

Interface
REQ-001 Parameter GROUND_Y, default 420: resting top-edge y of the player (480-line screen minus 60-pixel player).
REQ-002 Parameter JUMP_VEL, default 12: initial upward speed, in pixels per frame.
REQ-003 Parameter GRAVITY, default 1: speed change per frame.
REQ-004 Parameter MAX_FALL, default 15: downward speed cap, in pixels per frame.
REQ-005 Ports (clock and reset first):
- clk_i  in  1: the single clock.
- rst_i  in  1: asynchronous, active-high reset.
- frame_tick_i  in  1: one-cycle pulse per video frame.
- jump_i  in  1: raw jump button level, already synchronised.
- freeze_i  in  1: game paused.
- luc_loc_o  out  9: player top-edge y, fed to the player draw block's luc_loc_i.
- airborne_o  out  1: state is not IDLE.
- landed_o  out  1: one-cycle pulse on landing.

Function
REQ-006 The block SHALL use three states: IDLE (on ground), RISE and FALL.
REQ-007 The block SHALL hold an unsigned 5-bit velocity register vel; all y arithmetic SHALL be 10-bit before clamping to 9 bits.
REQ-008 A rising edge of jump_i SHALL set a pending flag; the edge and the tick in the same cycle count as pending for that tick.
REQ-009 Position and state SHALL update only on cycles with frame_tick_i=1 and freeze_i=0, and the new values SHALL appear the next cycle.
REQ-010 With freeze_i=1, ticks SHALL be ignored and all state held; the pending flag SHALL still be set by edges.
REQ-011 IDLE on tick with pending=1: next state RISE, vel=JUMP_VEL, y unchanged, pending cleared.
REQ-012 IDLE on tick with pending=0: no change.
REQ-013 RISE on tick: y=y-vel and vel=vel-GRAVITY; if the new vel is 0, next state FALL.
REQ-014 RISE ceiling: if y<vel, then y=0, vel=0 and next state FALL.
REQ-015 FALL on tick: vel=min(vel+GRAVITY, MAX_FALL) and y_next=y+vel_new.
REQ-016 FALL landing: if y_next>=GROUND_Y, then y=GROUND_Y, vel=0, next state IDLE, and landed_o=1 for exactly the cycle after that tick.
REQ-017 Every airborne tick SHALL clear pending, so presses made in the air are discarded (base configuration).
REQ-018 luc_loc_o SHALL never exceed GROUND_Y.
REQ-019 luc_loc_o, airborne_o and landed_o SHALL all be registered outputs.

Reset
REQ-020 Asserting rst_i SHALL asynchronously force the following, including mid-jump: state IDLE, luc_loc_o=GROUND_Y, vel=0, pending=0, airborne_o=0, landed_o=0, and the edge-detector history cleared.
REQ-021 The first tick after reset release SHALL behave as an IDLE tick.

Configuration
REQ-022 With macro PLAYER_DOUBLE_JUMP_EN defined: in RISE or FALL, a tick with pending=1 and dj_used=0 SHALL set vel=JUMP_VEL, state RISE and dj_used=1, applying the RISE rule from the following tick.
REQ-023 With PLAYER_DOUBLE_JUMP_EN defined: dj_used SHALL clear on landing and on reset.
REQ-024 Without PLAYER_DOUBLE_JUMP_EN: dj_used and its logic SHALL be absent, and REQ-017 applies.

Structure
REQ-025 Package player_pkg SHALL hold:
- the state enum (IDLE/RISE/FALL);
- SCREEN_H=480 and PLAYER_H=60;
- default GROUND_Y, JUMP_VEL, GRAVITY and MAX_FALL.
REQ-026 The jump_i rising-edge detector SHALL be a sub-module btn_edge (input level, output one-cycle pulse, async reset).

Verification
REQ-027 Reset, then 5 ticks with no jump: luc_loc_o=420 and airborne_o=0 throughout.
REQ-028 Single jump pulse then ticks:
- tick 1 → state RISE, y=420;
- after 12 RISE ticks → y=342 apex, state FALL;
- after 12 FALL ticks → y=420, landed_o pulses once;
- total 25 ticks.
REQ-029 Jump edge on the same cycle as a tick: jump is taken on that tick; a second press during RISE (macro off) is ignored and the landing tick is unchanged.
REQ-030 freeze_i=1 mid-RISE for 10 ticks: y and vel held; motion resumes identically after freeze_i=0.
REQ-031 rst_i asserted mid-FALL between clock edges: outputs go to 420/0/0 immediately, without waiting for a clock edge.
REQ-032 PLAYER_DOUBLE_JUMP_EN defined, second press at apex (y=342): vel restarts at 12, new apex 264; a third press is ignored; landing occurs at y=420.
